// File: rtl/dcache_ctrl_param.sv
// Direct-mapped write-back/write-allocate data cache with controller and flush walker.
// CPU side is a hold-until-d_rdy port; memory side is a level request with mem_rdy completion.
module dcache_ctrl_param #(
    parameter int ADDR_W         = 13,
    parameter int DATA_W         = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int INDEX_W        = 6
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [ADDR_W-1:0]                              addr,
    input  logic                                           re,
    input  logic                                           we,
    input  logic [DATA_W-1:0]                              wrt_data,
    input  logic                                           flush,
    output logic [DATA_W-1:0]                              rd_data,
    output logic                                           d_rdy,
    output logic                                           flush_done,
    output logic [ADDR_W-$clog2(WORDS_PER_LINE)-1:0]       mem_addr,
    output logic                                           mem_re,
    output logic                                           mem_we,
    output logic [DATA_W*WORDS_PER_LINE-1:0]               mem_wdata,
    input  logic [DATA_W*WORDS_PER_LINE-1:0]               mem_rdata,
    input  logic                                           mem_rdy
);
    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int TAG_W  = ADDR_W - OFF_W - INDEX_W;
    localparam int LINE_W = DATA_W * WORDS_PER_LINE;
    localparam int LINES  = 1 << INDEX_W;
    localparam logic [INDEX_W-1:0] LAST_IDX = {INDEX_W{1'b1}};
    localparam logic [INDEX_W-1:0] ONE_IDX  = INDEX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_EVICT      = 3'd1,
        S_FILL       = 3'd2,
        S_FLUSH_SCAN = 3'd3,
        S_FLUSH_WB   = 3'd4
    } state_t;

    state_t              r_state;
    logic [TAG_W-1:0]    r_tag  [LINES];
    logic [LINE_W-1:0]   r_line [LINES];
    logic [LINES-1:0]    r_valid;
    logic [LINES-1:0]    r_dirty;
    logic [INDEX_W-1:0]  r_fcnt;
    logic                r_flush_done;

    logic [OFF_W-1:0]    w_off;
    logic [INDEX_W-1:0]  w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic                w_req;
    logic                w_wr_op;
    logic                w_hit;
    logic                w_flushing;
    logic [INDEX_W-1:0]  w_sel_idx;
    logic                w_arr_we;
    logic [LINE_W-1:0]   w_arr_line;

    function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                     input logic [OFF_W-1:0]  off,
                                                     input logic [DATA_W-1:0] data);
        logic [LINE_W-1:0] res;
        res = line;
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            if (off == i[OFF_W-1:0]) res[i*DATA_W +: DATA_W] = data;
        end
        return res;
    endfunction

    function automatic logic [DATA_W-1:0] pick_word(input logic [LINE_W-1:0] line,
                                                    input logic [OFF_W-1:0]  off);
        logic [DATA_W-1:0] res;
        res = line[DATA_W-1:0];
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            if (off == i[OFF_W-1:0]) res = line[i*DATA_W +: DATA_W];
        end
        return res;
    endfunction

    assign w_off      = addr[OFF_W-1:0];
    assign w_idx      = addr[OFF_W +: INDEX_W];
    assign w_tag      = addr[ADDR_W-1 -: TAG_W];
    assign w_req      = re | we;
    assign w_wr_op    = we & ~re;
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_flushing = (r_state == S_FLUSH_SCAN) || (r_state == S_FLUSH_WB);
    assign w_sel_idx  = w_flushing ? r_fcnt : w_idx;

    // CPU-facing read data and handshake, plus memory request decode from state
    always_comb begin
        rd_data    = pick_word(r_line[w_idx], w_off);
        mem_wdata  = r_line[w_sel_idx];
        mem_re     = (r_state == S_FILL);
        mem_we     = (r_state == S_EVICT) || (r_state == S_FLUSH_WB);
        flush_done = r_flush_done;
        if (mem_we) begin
            mem_addr = {r_tag[w_sel_idx], w_sel_idx};
        end else begin
            mem_addr = {w_tag, w_idx};
        end
        if (r_state == S_IDLE) begin
            d_rdy = !(w_req && !w_hit);
        end else begin
            d_rdy = 1'b0;
        end
    end

    // Line write source: write-hit merge in IDLE or fill (optionally merged) on mem_rdy
    always_comb begin
        w_arr_we   = 1'b0;
        w_arr_line = r_line[w_idx];
        if ((r_state == S_IDLE) && w_req && w_hit && w_wr_op) begin
            w_arr_we   = 1'b1;
            w_arr_line = merge_word(r_line[w_idx], w_off, wrt_data);
        end else if ((r_state == S_FILL) && mem_rdy) begin
            w_arr_we   = 1'b1;
            w_arr_line = w_wr_op ? merge_word(mem_rdata, w_off, wrt_data) : mem_rdata;
        end else begin
            w_arr_we   = 1'b0;
        end
    end

    // Tag/data storage; deliberately not reset, validity is tracked separately
    always_ff @(posedge clk) begin
        if (w_arr_we) begin
            r_line[w_idx] <= w_arr_line;
            r_tag[w_idx]  <= w_tag;
        end
    end

    // Controller FSM with valid/dirty bookkeeping and flush walker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_dirty      <= '0;
            r_fcnt       <= '0;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            if (w_wr_op) r_dirty[w_idx] <= 1'b1;
                        end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
                            r_state <= S_EVICT;
                        end else begin
                            r_state <= S_FILL;
                        end
                    end else if (flush) begin
                        r_fcnt  <= '0;
                        r_state <= S_FLUSH_SCAN;
                    end
                end
                S_EVICT: begin
                    if (mem_rdy) r_state <= S_FILL;
                end
                S_FILL: begin
                    if (mem_rdy) begin
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= w_wr_op;
                        r_state        <= S_IDLE;
                    end
                end
                S_FLUSH_SCAN: begin
                    if (r_valid[r_fcnt] && r_dirty[r_fcnt]) begin
                        r_state <= S_FLUSH_WB;
                    end else begin
                        r_fcnt <= r_fcnt + ONE_IDX;
                        if (r_fcnt == LAST_IDX) begin
                            r_state      <= S_IDLE;
                            r_flush_done <= 1'b1;
                        end
                    end
                end
                S_FLUSH_WB: begin
                    if (mem_rdy) begin
                        r_dirty[r_fcnt] <= 1'b0;
                        r_fcnt          <= r_fcnt + ONE_IDX;
                        if (r_fcnt == LAST_IDX) begin
                            r_state      <= S_IDLE;
                            r_flush_done <= 1'b1;
                        end else begin
                            r_state <= S_FLUSH_SCAN;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/dcache_ctrl_param.md
# dcache_ctrl_param

Parametrised, direct-mapped, write-back/write-allocate data cache with integrated controller, sitting between the CPU data port and the line-wide data memory. Generalises the fixed 4-word/64-line data memory hierarchy: line size, index depth, address and data widths are parameters, tag/data arrays are internal, and a new flush mode walks every line and writes back all dirty lines. The memory side is a level request / `mem_rdy` handshake compatible with the existing `d_mem`.

## Interface
- `ADDR_W`, 13, CPU word-address width
- `DATA_W`, 16, CPU word width
- `WORDS_PER_LINE`, 4, words per line; power of 2, ≥2; `OFF_W` = log2(WORDS_PER_LINE)
- `INDEX_W`, 6, index bits (2^INDEX_W lines); `TAG_W` = ADDR_W−OFF_W−INDEX_W ≥1; `LINE_W` = DATA_W·WORDS_PER_LINE
- `clk` in 1: clock. One clock; all state on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `addr` in ADDR_W: CPU word address
- `re`, `we` in 1: CPU read / write enable
- `wrt_data` in DATA_W: CPU write data
- `flush` in 1: level flush request
- `rd_data` out DATA_W: word `addr[OFF_W-1:0]` of the indexed line
- `d_rdy` out 1: access complete / controller ready
- `flush_done` out 1: one-cycle pulse at flush completion
- `mem_addr` out ADDR_W−OFF_W: line address to memory
- `mem_re`, `mem_we` out 1: memory read / write request (level)
- `mem_wdata` out LINE_W: eviction line
- `mem_rdata` in LINE_W: fill line
- `mem_rdy` in 1: memory op complete

## Operation
- Address split: offset = `addr[OFF_W-1:0]`, index = next INDEX_W bits, tag = top TAG_W bits. Hit = valid[index] && tag match.
- `re` has priority over `we`; both high = read. `flush` accepted only in IDLE with `re`=`we`=0.
- States: IDLE, EVICT, FILL, FLUSH_SCAN, FLUSH_WB.
- IDLE: read hit → `d_rdy`=1, stay. Write hit → `d_rdy`=1, word merged into line, dirty set at clock edge. Miss with dirty victim → EVICT; clean/invalid victim → FILL. Both with `d_rdy`=0.
- EVICT: `mem_we`=1, `mem_addr`={stored tag,index}, `mem_wdata`=stored line; on `mem_rdy` → FILL.
- FILL: `mem_re`=1, `mem_addr`={addr tag,index}; on `mem_rdy` line written (write miss: `wrt_data` merged at offset, dirty=1; read miss: dirty=0), valid=1, tag updated → IDLE.
- FLUSH_SCAN: counter from index 0; dirty line → FLUSH_WB; else advance. After last index (counter wraps to 0) → IDLE with `flush_done`=1 that cycle.
- FLUSH_WB: `mem_we`=1 with that line; on `mem_rdy` clear dirty (valid kept), advance, → FLUSH_SCAN (or IDLE+`flush_done` if last).
- `d_rdy`=0 in every state except IDLE; in IDLE `d_rdy`=0 only on a miss.
- `mem_rdy` ignored when no request is asserted. `mem_re` and `mem_we` never high together.

## Timing
- Reset: state IDLE, all valid/dirty cleared, flush counter 0, `mem_re`=`mem_we`=`flush_done`=0, `d_rdy`=1 (no request). Data/tag arrays not reset.
- Hit: combinational, 0 added cycles; `rd_data` valid same cycle.
- Clean miss: FILL entered next edge; line installed on `mem_rdy` edge; hit in IDLE the following cycle. Dirty miss adds EVICT duration.
- CPU holds `addr`, `re`, `we`, `wrt_data` stable while `d_rdy`=0.
- Request asserted from state entry through the `mem_rdy` cycle; deasserts (or switches op) next cycle.
- Flush: ≥1 cycle per clean line plus each write-back's memory latency.
- `rst_n` low mid-operation: requests drop immediately (async), any in-flight line discarded, cache empty after release.

## Test plan
- Reset, read `addr`=0x0004 → FILL, `mem_re`=1, `mem_addr`=0x001 until `mem_rdy`; return 0x4444_3333_2222_1111 → next cycle `d_rdy`=1, `rd_data`=0x1111.
- Then write 0x0005 = 0xBEEF → `d_rdy`=1 same cycle, no memory traffic; read 0x0005 → 0xBEEF.
- Then read 0x0104 (index 1, tag 1) → EVICT `mem_we`=1, `mem_addr`=0x001, `mem_wdata`=0x4444_3333_BEEF_1111; then FILL `mem_addr`=0x041.
- Write miss 0x0200 = 0x1234 to clean index 0 → FILL only, `mem_we` never high; read 0x0200 → 0x1234, line dirty.
- Two dirty lines (indices 0, 1), assert `flush` → exactly two `mem_we` bursts, index 0 then 1, one `flush_done` pulse after index 63; second flush → zero writes.
- `rst_n` low during FILL → `mem_re` drops same cycle; after release read 0x0004 misses again.
